// File: rtl/rr_arbiter_4_v_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Imported by the picker and the top-level FSM.
package rr_arbiter_4_v_pkg;

   localparam int NUM_REQ  = 4;
   localparam int REQ_ID_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   function automatic logic [NUM_REQ-1:0] onehot4(
      input logic [REQ_ID_W-1:0] id
   );
      return NUM_REQ'(1) << id;
   endfunction

endpackage

// File: rtl/rr_arbiter_4_v_pick.sv
// Combinational rotating priority picker: first set request
// at or after ptr, wrapping modulo 4.
module rr_pick_4_v
   import rr_arbiter_4_v_pkg::*;
(
   input  logic [NUM_REQ-1:0]  req,
   input  logic [REQ_ID_W-1:0] ptr,
   output logic [REQ_ID_W-1:0] id,
   output logic                any
);

   logic [NUM_REQ-1:0]  rot;
   logic [REQ_ID_W-1:0] enc;

   // rot[i] = req[(i + ptr) mod 4]
   assign rot = NUM_REQ'({req, req} >> ptr);

   always_comb begin
      enc = '0;
      priority case (1'b1)
         rot[0]:  enc = 2'd0;
         rot[1]:  enc = 2'd1;
         rot[2]:  enc = 2'd2;
         rot[3]:  enc = 2'd3;
         default: enc = 2'd0;
      endcase
   end

   assign id  = enc + ptr;
   assign any = |req;

endmodule

// File: rtl/rr_arbiter_4_v.sv
// Four-requester round-robin arbiter with registered, held grant
// and an optional hold timeout that reclaims the resource.
module rr_arbiter_4_v
   import rr_arbiter_4_v_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
)
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_en,
   input  logic [NUM_REQ-1:0]  i_req,
   output logic [NUM_REQ-1:0]  o_gnt,
   output logic [REQ_ID_W-1:0] o_gnt_id,
   output logic                o_valid,
   output logic                o_timeout
);

   localparam logic [CNT_W-1:0] HOLD_LAST =
      CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e              state_q, state_d;
   logic [REQ_ID_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [REQ_ID_W-1:0] gnt_id_q, gnt_id_d;
   logic                timeout_q, timeout_d;

   logic [REQ_ID_W-1:0] pick_id;
   logic                pick_any;
   logic                owner_req;
   logic                hold_expired;

   rr_pick_4_v u_pick (
      .req (i_req),
      .ptr (ptr_q),
      .id  (pick_id),
      .any (pick_any)
   );

   assign owner_req    = i_req[gnt_id_q];
   assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      timeout_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_en && pick_any) begin
               state_d  = ST_GRANT;
               gnt_d    = onehot4(pick_id);
               gnt_id_d = pick_id;
               cnt_d    = '0;
            end
         end
         ST_GRANT: begin
            // Any release advances ptr past the owner for fairness
            if (!owner_req || hold_expired) begin
               state_d   = ST_IDLE;
               gnt_d     = '0;
               ptr_d     = gnt_id_q + 2'd1;
               timeout_d = owner_req;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_gnt     = gnt_q;
   assign o_gnt_id  = gnt_id_q;
   assign o_valid   = (state_q == ST_GRANT);
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4_v.sv
// Vector-table and scoreboard bench for rr_arbiter_4_v with a
// 4-cycle hold limit.
module tb_rr_arbiter_4_v;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] id;
      logic       v;
      logic       to;
   } out_t;

   typedef struct packed {
      logic [3:0] req;
      logic       en;
      out_t       exp;
   } vec_t;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_en = 1'b0;
   logic [3:0] i_req = 4'b0000;
   logic [3:0] o_gnt;
   logic [1:0] o_gnt_id;
   logic       o_valid;
   logic       o_timeout;

   int   tests = 0;
   int   fails = 0;
   out_t exp_q[$];
   vec_t tv[$];

   rr_arbiter_4_v #(.MAX_HOLD(4), .CNT_W(5)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (i_en),
      .i_req     (i_req),
      .o_gnt     (o_gnt),
      .o_gnt_id  (o_gnt_id),
      .o_valid   (o_valid),
      .o_timeout (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   task automatic add(input logic [3:0] req, input logic en,
                      input logic [3:0] gnt, input logic [1:0] id,
                      input logic v, input logic to);
      vec_t t;
      t.req = req;
      t.en  = en;
      t.exp = '{gnt: gnt, id: id, v: v, to: to};
      tv.push_back(t);
   endtask

   task automatic check(input string name);
      out_t e;
      out_t a;
      a = '{gnt: o_gnt, id: o_gnt_id, v: o_valid, to: o_timeout};
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            fails++;
            $display("FAIL %s: got gnt=%b id=%0d v=%b to=%b, want gnt=%b id=%0d v=%b to=%b",
                     name, a.gnt, a.id, a.v, a.to, e.gnt, e.id, e.v, e.to);
         end
      end
   endtask

   task automatic step(input string name, input logic [3:0] req,
                       input logic en, input out_t e);
      i_req = req;
      i_en  = en;
      exp_q.push_back(e);
      @(posedge i_clk);
      #1;
      check(name);
   endtask

   initial begin
      // rotation with all requesting, ptr starts at 0
      add(4'b1111, 1, 4'b0001, 0, 1, 0);
      add(4'b1110, 1, 4'b0000, 0, 0, 0);
      add(4'b1111, 1, 4'b0010, 1, 1, 0);
      add(4'b1101, 1, 4'b0000, 1, 0, 0);
      add(4'b1111, 1, 4'b0100, 2, 1, 0);
      add(4'b1011, 1, 4'b0000, 2, 0, 0);
      add(4'b1111, 1, 4'b1000, 3, 1, 0);
      add(4'b0111, 1, 4'b0000, 3, 0, 0);
      add(4'b1111, 1, 4'b0001, 0, 1, 0);
      add(4'b1110, 1, 4'b0000, 0, 0, 0);
      add(4'b0000, 1, 4'b0000, 0, 0, 0);
      // single request from ptr=1
      add(4'b0100, 1, 4'b0100, 2, 1, 0);
      add(4'b0000, 1, 4'b0000, 2, 0, 0);
      // wrap from ptr=3
      add(4'b0011, 1, 4'b0001, 0, 1, 0);
      add(4'b0010, 1, 4'b0000, 0, 0, 0);
      add(4'b0011, 1, 4'b0010, 1, 1, 0);
      add(4'b0001, 1, 4'b0000, 1, 0, 0);
      // ptr=2: 0 beats 1; later 1 re-wins only as sole requester
      add(4'b0011, 1, 4'b0001, 0, 1, 0);
      add(4'b0010, 1, 4'b0000, 0, 0, 0);
      add(4'b0010, 1, 4'b0010, 1, 1, 0);
      add(4'b0000, 1, 4'b0000, 1, 0, 0);
      add(4'b0010, 1, 4'b0010, 1, 1, 0);
      add(4'b0000, 1, 4'b0000, 1, 0, 0);
      // timeout: requester 1 holds, grant lasts 4 cycles
      add(4'b0010, 1, 4'b0010, 1, 1, 0);
      add(4'b0010, 1, 4'b0010, 1, 1, 0);
      add(4'b0010, 1, 4'b0010, 1, 1, 0);
      add(4'b0010, 1, 4'b0010, 1, 1, 0);
      add(4'b0010, 1, 4'b0000, 1, 0, 1);
      add(4'b0011, 1, 4'b0001, 0, 1, 0);
      add(4'b0010, 1, 4'b0000, 0, 0, 0);
      add(4'b0010, 1, 4'b0010, 1, 1, 0);
      add(4'b0000, 1, 4'b0000, 1, 0, 0);

      // reset state
      #1;
      exp_q.push_back('{gnt: 4'b0000, id: 2'd0, v: 1'b0, to: 1'b0});
      check("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      foreach (tv[k])
         step($sformatf("vec%0d", k), tv[k].req, tv[k].en, tv[k].exp);

      // enable gating, ptr=2 here
      for (int k = 0; k < 10; k++)
         step($sformatf("en_off%0d", k), 4'b1000, 1'b0,
              '{gnt: 4'b0000, id: 2'd1, v: 1'b0, to: 1'b0});
      step("en_on", 4'b1000, 1'b1,
           '{gnt: 4'b1000, id: 2'd3, v: 1'b1, to: 1'b0});
      for (int k = 0; k < 3; k++)
         step($sformatf("en_hold%0d", k), 4'b1000, 1'b0,
              '{gnt: 4'b1000, id: 2'd3, v: 1'b1, to: 1'b0});
      step("en_rel", 4'b0000, 1'b0,
           '{gnt: 4'b0000, id: 2'd3, v: 1'b0, to: 1'b0});

      // move ptr to 3, then reset mid-grant
      step("pre_g", 4'b0100, 1'b1,
           '{gnt: 4'b0100, id: 2'd2, v: 1'b1, to: 1'b0});
      step("pre_r", 4'b0000, 1'b1,
           '{gnt: 4'b0000, id: 2'd2, v: 1'b0, to: 1'b0});
      step("mid_g", 4'b0100, 1'b1,
           '{gnt: 4'b0100, id: 2'd2, v: 1'b1, to: 1'b0});
      i_rst_n = 1'b0;
      #2;
      exp_q.push_back('{gnt: 4'b0000, id: 2'd0, v: 1'b0, to: 1'b0});
      check("async_rst");
      #2;
      i_rst_n = 1'b1;
      // ptr back at 0: requester 0 beats 3
      step("post_rst", 4'b1001, 1'b1,
           '{gnt: 4'b0001, id: 2'd0, v: 1'b1, to: 1'b0});
      step("post_rel", 4'b0000, 1'b1,
           '{gnt: 4'b0000, id: 2'd0, v: 1'b0, to: 1'b0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
